regressive_counter_ctrl: RTL

Sequencer for the N-bit regressive (down) counter with dual 7-segment display. It turns two raw push-button inputs (start, pause) into clean control for the counter. Controls produced: a one-cycle load of the start value, periodic one-cycle decrement pulses at a programmable rate, pause/resume, and a terminal-zero DONE indication. It sits between the board buttons/switches and the counter datapath, and reads the counter value back to detect zero.

---
 rtl/regressive_counter_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/regressive_counter_ctrl.sv
// Button-driven sequencer for a down counter: load, paced decrement, pause/resume, done.
// Raw buttons are synchronised, edge-detected and registered before the FSM acts on them.
//
//   state  | meaning
//   IDLE   | waiting for the first start press
//   LOAD   | one cycle: counter loads load_value, prescaler cleared
//   RUN    | prescaler running, decrement pulse every TICK_DIV cycles
//   PAUSED | prescaler frozen, no decrements
//   DONE   | counter reached zero, waiting for a new start
module regressive_counter_ctrl #(
  parameter int N        = 6,
  parameter int TICK_DIV = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic [N-1:0] start_value,
  input  logic [N-1:0] count,
  output logic         load,
  output logic [N-1:0] load_value,
  output logic         decrement,
  output logic         busy,
  output logic         done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic [N-1:0]  lv_nxt;
  logic          dec_nxt;

  logic [2:0] start_sync, pause_sync;
  logic [1:0] live;
  logic       start_armed, pause_armed;
  logic       start_evt, pause_evt;

  // A button must be seen low after reset before its rising edge counts; live marks
  // when the synchroniser holds a real sample rather than its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sync  <= '0;
      pause_sync  <= '0;
      live        <= '0;
      start_armed <= 1'b0;
      pause_armed <= 1'b0;
      start_evt   <= 1'b0;
      pause_evt   <= 1'b0;
    end else begin
      start_sync  <= {start_sync[1:0], start};
      pause_sync  <= {pause_sync[1:0], pause};
      live        <= {live[0], 1'b1};
      start_armed <= start_armed | (live[1] & ~start_sync[1]);
      pause_armed <= pause_armed | (live[1] & ~pause_sync[1]);
      start_evt   <= start_sync[1] & ~start_sync[2] & start_armed;
      pause_evt   <= pause_sync[1] & ~pause_sync[2] & pause_armed;
    end
  end

  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    lv_nxt    = load_value;
    dec_nxt   = 1'b0;
    case (state)
      IDLE, DONE: if (start_evt) state_nxt = LOAD;
      LOAD:       state_nxt = RUN;
      RUN: begin
        if (start_evt)               state_nxt = LOAD;
        else if (count == '0)        state_nxt = DONE;
        else if (pause_evt)          state_nxt = PAUSED;
        else if (psc == TICK_LAST) begin
          dec_nxt = 1'b1;
          psc_nxt = '0;
        end else                     psc_nxt = psc + 1'b1;
      end
      PAUSED: begin
        if (start_evt)      state_nxt = LOAD;
        else if (pause_evt) state_nxt = RUN;
      end
      default:    state_nxt = IDLE;
    endcase
    // Start always wins, so every entry into LOAD captures a fresh value and restarts the pace.
    if (state_nxt == LOAD) begin
      psc_nxt = '0;
      lv_nxt  = start_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      psc        <= '0;
      load_value <= '0;
      load       <= 1'b0;
      decrement  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      psc        <= psc_nxt;
      load_value <= lv_nxt;
      load       <= (state_nxt == LOAD);
      decrement  <= dec_nxt;
      busy       <= (state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == PAUSED);
      done       <= (state_nxt == DONE);
    end
  end

endmodule
